// File: rtl/mem_access_unit_pkg.sv
// Shared opcode constants, load/store classification and common types for the MEM-stage access unit.
`ifndef MEM_ACCESS_UNIT_OPS_SVH
`define MEM_ACCESS_UNIT_OPS_SVH
`define OP_LB  6'h20
`define OP_LH  6'h21
`define OP_LWL 6'h22
`define OP_LW  6'h23
`define OP_LBU 6'h24
`define OP_LHU 6'h25
`define OP_LWR 6'h26
`define OP_SB  6'h28
`define OP_SH  6'h29
`define OP_SWL 6'h2A
`define OP_SW  6'h2B
`define OP_SWR 6'h2E
`define OP_LL  6'h30
`define OP_SC  6'h38
`define IS_LOAD(op)  (((op) == `OP_LB)  || ((op) == `OP_LBU) || ((op) == `OP_LH)  || \
                      ((op) == `OP_LHU) || ((op) == `OP_LW)  || ((op) == `OP_LWL) || \
                      ((op) == `OP_LWR) || ((op) == `OP_LL))
`define IS_STORE(op) (((op) == `OP_SB)  || ((op) == `OP_SH)  || ((op) == `OP_SW)  || \
                      ((op) == `OP_SWL) || ((op) == `OP_SWR) || ((op) == `OP_SC))
`endif

package mem_access_unit_pkg;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned SEL_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mem_access_unit_load_align.sv
// Return-path formatting: big-endian byte/halfword extraction, extension and LWL/LWR merge with rt.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [OP_W-1:0]       op_i,
  input  logic [BYTE_OFF_W-1:0] off_i,
  input  logic [DATA_W-1:0]     rt_i,
  input  logic [DATA_W-1:0]     rdata_i,
  output logic [DATA_W-1:0]     data_o
);
  localparam logic [DATA_W-1:0] ONES = '1;

  logic [4:0]        sh_l;
  logic [4:0]        sh_r;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  // Byte offset 0 is the most significant byte, so left shifts bring the addressed byte to the top.
  always_comb begin
    sh_l   = {off_i, 3'b000};
    sh_r   = {~off_i, 3'b000};
    lane_b = 8'((rdata_i << sh_l) >> 24);
    lane_h = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    data_o = rdata_i;
    case (op_i)
      `OP_LB:  data_o = {{24{lane_b[7]}}, lane_b};
      `OP_LBU: data_o = {24'h000000, lane_b};
      `OP_LH:  data_o = {{16{lane_h[15]}}, lane_h};
      `OP_LHU: data_o = {16'h0000, lane_h};
      `OP_LWL: data_o = (rdata_i << sh_l) | (rt_i & ~(ONES << sh_l));
      `OP_LWR: data_o = (rdata_i >> sh_r) | (rt_i & ~(ONES >> sh_r));
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: bus handshake, store formatting, load return and LL/SC link tracking.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [OP_W-1:0]       i_instr_op,
  input  logic [ADDR_W-1:0]     i_mem_addr,
  input  logic [BYTE_OFF_W-1:0] i_byte_off,
  input  logic [SEL_W-1:0]      i_mem_sel,
  input  logic                  i_bad_addr,
  input  logic [DATA_W-1:0]     i_rt_value,
  input  logic                  i_eret,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_W-1:0]     o_load_data,
  output logic                  o_sc_result,
  output logic                  o_exc_adel,
  output logic                  o_exc_ades,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [ADDR_W-1:0]     o_bus_addr,
  output logic [SEL_W-1:0]      o_bus_sel,
  output logic [DATA_W-1:0]     o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [DATA_W-1:0]     i_bus_rdata
);
  state_e            state_q;
  logic              link_q;
  logic [ADDR_W-1:0] link_addr_q;

  logic              is_ld;
  logic              is_st;
  logic              is_mem;
  logic              is_ll;
  logic              is_sc;
  logic              sc_ok;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;

  // Opcode decode and SC link match.
  always_comb begin
    is_ld  = `IS_LOAD(i_instr_op);
    is_st  = `IS_STORE(i_instr_op);
    is_mem = is_ld || is_st;
    is_ll  = (i_instr_op == `OP_LL);
    is_sc  = (i_instr_op == `OP_SC);
    sc_ok  = link_q && (i_mem_addr == link_addr_q);
  end

  // Store data placement on the big-endian bus.
  always_comb begin
    st_data = i_rt_value;
    case (i_instr_op)
      `OP_SB:  st_data = {4{i_rt_value[7:0]}};
      `OP_SH:  st_data = {2{i_rt_value[15:0]}};
      `OP_SWL: st_data = i_rt_value >> {i_byte_off, 3'b000};
      `OP_SWR: st_data = i_rt_value << {~i_byte_off, 3'b000};
      default: st_data = i_rt_value;
    endcase
  end

  mem_access_unit_load_align u_load_align (
    .op_i    (i_instr_op),
    .off_i   (i_byte_off),
    .rt_i    (i_rt_value),
    .rdata_i (i_bus_rdata),
    .data_o  (ld_data)
  );

  // Stall is immediate on accept; reset drops it so a flushed access never holds the pipe.
  assign o_stall = !i_rst && ((state_q == ST_IDLE) ? (i_valid && is_mem) : (state_q == ST_BUSY));

  // Access state machine with registered bus/result outputs and the LL/SC link register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      link_q      <= 1'b0;
      link_addr_q <= '0;
      o_done      <= 1'b0;
      o_load_data <= '0;
      o_sc_result <= 1'b0;
      o_exc_adel  <= 1'b0;
      o_exc_ades  <= 1'b0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_sel   <= '0;
      o_bus_wdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && is_mem) begin
            if (i_bad_addr) begin
              o_exc_adel <= is_ld;
              o_exc_ades <= is_st;
              o_done     <= 1'b1;
              state_q    <= ST_RESP;
            end else if (is_sc && !sc_ok) begin
              o_sc_result <= 1'b0;
              o_done      <= 1'b1;
              link_q      <= 1'b0;
              state_q     <= ST_RESP;
            end else begin
              o_bus_req   <= 1'b1;
              o_bus_we    <= is_st;
              o_bus_addr  <= i_mem_addr;
              o_bus_sel   <= i_mem_sel;
              o_bus_wdata <= st_data;
              state_q     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (i_bus_ack) begin
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_load_data <= is_ld ? ld_data : '0;
            o_sc_result <= is_sc;
            o_done      <= 1'b1;
            if (is_ll) begin
              link_q      <= 1'b1;
              link_addr_q <= i_mem_addr;
            end
            if (is_sc) begin
              link_q <= 1'b0;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          o_done      <= 1'b0;
          o_load_data <= '0;
          o_sc_result <= 1'b0;
          o_exc_adel  <= 1'b0;
          o_exc_ades  <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // ERET has the last word on the link bit, including over a same-cycle LL ack.
      if (i_eret) begin
        link_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, LL/SC, address errors and reset during a bus access.
module tb_mem_access_unit;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [5:0]  i_instr_op;
  logic [31:0] i_mem_addr;
  logic [1:0]  i_byte_off;
  logic [3:0]  i_mem_sel;
  logic        i_bad_addr;
  logic [31:0] i_rt_value;
  logic        i_eret;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_load_data;
  logic        o_sc_result;
  logic        o_exc_adel;
  logic        o_exc_ades;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_instr_op  (i_instr_op),
    .i_mem_addr  (i_mem_addr),
    .i_byte_off  (i_byte_off),
    .i_mem_sel   (i_mem_sel),
    .i_bad_addr  (i_bad_addr),
    .i_rt_value  (i_rt_value),
    .i_eret      (i_eret),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_load_data (o_load_data),
    .o_sc_result (o_sc_result),
    .o_exc_adel  (o_exc_adel),
    .o_exc_ades  (o_exc_ades),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_sel   (o_bus_sel),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [1:0] off,
                       input logic [3:0] sel, input logic [31:0] rt, input logic bad);
    i_valid    = 1'b1;
    i_instr_op = op;
    i_mem_addr = addr;
    i_byte_off = off;
    i_mem_sel  = sel;
    i_rt_value = rt;
    i_bad_addr = bad;
  endtask

  // Hold ack low for 'waits' cycles, then ack for one cycle with the given read data.
  task automatic bus_ack(input int waits, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) tick();
    i_bus_ack   = 1'b1;
    i_bus_rdata = rdata;
    tick();
    i_bus_ack   = 1'b0;
  endtask

  // Leave RESP and retire the instruction.
  task automatic retire();
    tick();
    i_valid    = 1'b0;
    i_instr_op = 6'h00;
    i_bad_addr = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_instr_op = 6'h00; i_mem_addr = '0; i_byte_off = '0;
    i_mem_sel = '0; i_bad_addr = 1'b0; i_rt_value = '0; i_eret = 1'b0;
    i_bus_ack = 1'b0; i_bus_rdata = '0;
    tick(); tick();
    chk("rst_req", o_bus_req, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ldata", o_load_data, 0);
    chk("rst_wdata", o_bus_wdata, 0);
    i_rst = 1'b0;
    tick();

    // Non-memory op is ignored; stray ack in IDLE is ignored
    issue(6'h00, 32'h40, 2'd0, 4'hF, 32'h0, 1'b0);
    i_bus_ack = 1'b1;
    #1 chk("nonmem_stall", o_stall, 0);
    tick();
    i_bus_ack = 1'b0;
    chk("nonmem_req", o_bus_req, 0);
    chk("stray_ack_done", o_done, 0);
    i_valid = 1'b0;

    // LB off=1 with 2-cycle ack delay: done at T3
    issue(`OP_LB, 32'h200, 2'd1, 4'b0100, 32'h0, 1'b0);
    #1 chk("lb_t0_stall", o_stall, 1);
    chk("lb_t0_req", o_bus_req, 0);
    tick();
    chk("lb_t1_req", o_bus_req, 1);
    chk("lb_t1_we", o_bus_we, 0);
    chk("lb_t1_addr", o_bus_addr, 32'h200);
    chk("lb_t1_sel", o_bus_sel, 4'b0100);
    tick();
    chk("lb_t2_done", o_done, 0);
    chk("lb_t2_stall", o_stall, 1);
    bus_ack(0, 32'h11A23344);
    chk("lb_t3_done", o_done, 1);
    chk("lb_data", o_load_data, 32'hFFFFFFA2);
    chk("lb_t3_stall", o_stall, 0);
    chk("lb_t3_req", o_bus_req, 0);
    retire();
    chk("lb_done_clr", o_done, 0);
    chk("lb_data_clr", o_load_data, 0);

    // LBU same inputs, zero-wait ack: done at T2
    issue(`OP_LBU, 32'h200, 2'd1, 4'b0100, 32'h0, 1'b0);
    tick();
    bus_ack(0, 32'h11A23344);
    chk("lbu_done", o_done, 1);
    chk("lbu_data", o_load_data, 32'h000000A2);
    retire();

    // LH off=2 (lower half, negative) and LHU off=0 (upper half)
    issue(`OP_LH, 32'h204, 2'd2, 4'b0011, 32'h0, 1'b0);
    tick(); bus_ack(0, 32'h1234F00D);
    chk("lh_data", o_load_data, 32'hFFFFF00D);
    retire();
    issue(`OP_LHU, 32'h208, 2'd0, 4'b1100, 32'h0, 1'b0);
    tick(); bus_ack(1, 32'h8001ABCD);
    chk("lhu_data", o_load_data, 32'h00008001);
    retire();

    // LWL / LWR merge with rt
    issue(`OP_LWL, 32'h210, 2'd1, 4'b0111, 32'hAABBCCDD, 1'b0);
    tick(); bus_ack(0, 32'h11223344);
    chk("lwl_data", o_load_data, 32'h223344DD);
    retire();
    issue(`OP_LWR, 32'h210, 2'd1, 4'b1100, 32'hAABBCCDD, 1'b0);
    tick(); bus_ack(0, 32'h11223344);
    chk("lwr_data", o_load_data, 32'hAABB1122);
    retire();

    // Stores
    issue(`OP_SB, 32'h300, 2'd3, 4'b0001, 32'h000000EE, 1'b0);
    tick();
    chk("sb_we", o_bus_we, 1);
    chk("sb_wdata", o_bus_wdata, 32'hEEEEEEEE);
    chk("sb_sel", o_bus_sel, 4'b0001);
    bus_ack(0, 32'h0);
    chk("sb_done", o_done, 1);
    chk("sb_ldata", o_load_data, 0);
    retire();
    issue(`OP_SWL, 32'h304, 2'd2, 4'b0011, 32'h12345678, 1'b0);
    tick();
    chk("swl_wdata", o_bus_wdata, 32'h00001234);
    bus_ack(0, 32'h0);
    retire();
    issue(`OP_SWR, 32'h308, 2'd0, 4'b1000, 32'h12345678, 1'b0);
    tick();
    chk("swr_wdata", o_bus_wdata, 32'h78000000);
    bus_ack(0, 32'h0);
    retire();
    issue(`OP_SH, 32'h30C, 2'd2, 4'b0011, 32'h0000BEEF, 1'b0);
    tick();
    chk("sh_wdata", o_bus_wdata, 32'hBEEFBEEF);
    bus_ack(0, 32'h0);
    retire();

    // LL then SC succeeds, second SC fails without a bus request
    issue(`OP_LL, 32'h100, 2'd0, 4'hF, 32'h0, 1'b0);
    tick(); bus_ack(0, 32'hCAFEF00D);
    chk("ll_data", o_load_data, 32'hCAFEF00D);
    retire();
    issue(`OP_SC, 32'h100, 2'd0, 4'hF, 32'h00000055, 1'b0);
    tick();
    chk("sc1_req", o_bus_req, 1);
    chk("sc1_we", o_bus_we, 1);
    chk("sc1_wdata", o_bus_wdata, 32'h00000055);
    bus_ack(0, 32'h0);
    chk("sc1_done", o_done, 1);
    chk("sc1_result", o_sc_result, 1);
    retire();
    issue(`OP_SC, 32'h100, 2'd0, 4'hF, 32'h00000066, 1'b0);
    tick();
    chk("sc2_req", o_bus_req, 0);
    chk("sc2_done", o_done, 1);
    chk("sc2_result", o_sc_result, 0);
    retire();

    // LL, ERET, SC fails
    issue(`OP_LL, 32'h100, 2'd0, 4'hF, 32'h0, 1'b0);
    tick(); bus_ack(0, 32'h1);
    retire();
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    issue(`OP_SC, 32'h100, 2'd0, 4'hF, 32'h77, 1'b0);
    tick();
    chk("eret_sc_req", o_bus_req, 0);
    chk("eret_sc_result", o_sc_result, 0);
    chk("eret_sc_done", o_done, 1);
    retire();

    // ERET in the same cycle as the LL ack wins
    issue(`OP_LL, 32'h140, 2'd0, 4'hF, 32'h0, 1'b0);
    tick();
    i_eret = 1'b1;
    bus_ack(0, 32'h2);
    i_eret = 1'b0;
    retire();
    issue(`OP_SC, 32'h140, 2'd0, 4'hF, 32'h88, 1'b0);
    tick();
    chk("eret_ack_sc_req", o_bus_req, 0);
    chk("eret_ack_sc_result", o_sc_result, 0);
    retire();

    // Address errors
    issue(`OP_LW, 32'h400, 2'd1, 4'hF, 32'h0, 1'b1);
    #1 chk("adel_stall", o_stall, 1);
    tick();
    chk("adel_req", o_bus_req, 0);
    chk("adel_done", o_done, 1);
    chk("adel_flag", o_exc_adel, 1);
    chk("adel_ades", o_exc_ades, 0);
    retire();
    chk("adel_clr", o_exc_adel, 0);
    issue(`OP_SH, 32'h404, 2'd1, 4'b0011, 32'h0, 1'b1);
    tick();
    chk("ades_req", o_bus_req, 0);
    chk("ades_flag", o_exc_ades, 1);
    chk("ades_adel", o_exc_adel, 0);
    retire();

    // Reset mid-BUSY
    issue(`OP_LW, 32'h500, 2'd0, 4'hF, 32'h0, 1'b0);
    tick();
    chk("rb_req_before", o_bus_req, 1);
    i_rst = 1'b1;
    #1;
    chk("rb_req_now", o_bus_req, 0);
    chk("rb_stall_now", o_stall, 0);
    i_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    chk("rb_no_done1", o_done, 0);
    tick();
    chk("rb_no_done2", o_done, 0);
    issue(`OP_LW, 32'h504, 2'd0, 4'hF, 32'h0, 1'b0);
    tick();
    chk("rb_lw_req", o_bus_req, 1);
    bus_ack(0, 32'h89ABCDEF);
    chk("rb_lw_done", o_done, 1);
    chk("rb_lw_data", o_load_data, 32'h89ABCDEF);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
